// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed little-endian data memory for the MEM stage.
// Byte/half/word(/dword) accesses with sign or zero extension on loads,
// misalignment detection, a READ_LAT-deep in-order response pipeline and a
// hardware bulk-clear engine that zeroes one data word per cycle.
// Optional build macro: DMEM_STATS_EN adds saturating load/store/fault counters.
module dmem_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_misalign,
    input  logic              clr_start,
    output logic              clr_busy
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]       stat_loads,
    output logic [31:0]       stat_stores,
    output logic [31:0]       stat_faults
`endif
);

    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = $clog2(LANES);
    localparam int IDX_W  = ADDR_W - LANE_W;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  clr_idx;
    logic              clr_last;
    logic [7:0]        mem [DEPTH];

    logic              accept;
    logic              misalign;
    logic [ADDR_W-1:0] size_mask;
    int                nbytes;
    int                nbits;
    logic              sign_bit;
    logic [DATA_W-1:0] rd_raw;
    logic [DATA_W-1:0] load_data;

    logic              v_pipe [READ_LAT];
    logic              m_pipe [READ_LAT];
    logic [DATA_W-1:0] d_pipe [READ_LAT];

    // Access size decode and alignment check; dword is only legal on a 64-bit path
    always_comb begin
        nbytes    = 1 << req_size;
        nbits     = 8 << req_size;
        size_mask = ADDR_W'(nbytes - 1);
        misalign  = ((req_addr & size_mask) != '0) || (req_size == 2'd3 && DATA_W != 64);
    end

    // Gather a full data-width of bytes starting at the request address
    always_comb begin
        rd_raw = '0;
        for (int b = 0; b < LANES; b++) begin
            rd_raw[8*b +: 8] = mem[req_addr + ADDR_W'(b)];
        end
    end

    // Keep the low n bytes and extend from the top bit of the accessed size
    always_comb begin
        sign_bit = 1'b0;
        case (req_size)
            2'd0:    sign_bit = rd_raw[7];
            2'd1:    sign_bit = rd_raw[15];
            2'd2:    sign_bit = rd_raw[31];
            default: sign_bit = rd_raw[DATA_W-1];
        endcase
        if (req_unsigned) begin
            sign_bit = 1'b0;
        end
        load_data = '0;
        for (int i = 0; i < DATA_W; i++) begin
            load_data[i] = (i < nbits) ? rd_raw[i] : sign_bit;
        end
    end

    // Controller state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs; a clear request wins over a same-cycle access
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        clr_busy   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !clr_start && !rst;
                if (clr_start) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                clr_busy = 1'b1;
                if (clr_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept   = req_valid && req_ready;
    assign clr_last = (clr_idx == '1);

    // Clear word index walks upward during CLEAR and sits at zero otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_idx <= '0;
        end else if (state == CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
        end else begin
            clr_idx <= '0;
        end
    end

    // Byte array writes: one zeroed word per clear cycle, or the low n bytes of an aligned store
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                for (int b = 0; b < LANES; b++) begin
                    mem[{clr_idx, LANE_W'(b)}] <= 8'h00;
                end
            end else if (accept && req_we && !misalign) begin
                for (int b = 0; b < LANES; b++) begin
                    if (b < nbytes) begin
                        mem[req_addr + ADDR_W'(b)] <= req_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Response pipeline: stage 0 captures at the accept edge, the last stage drives the outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                v_pipe[i] <= 1'b0;
                m_pipe[i] <= 1'b0;
                d_pipe[i] <= '0;
            end
        end else begin
            v_pipe[0] <= accept;
            m_pipe[0] <= accept && misalign;
            d_pipe[0] <= (accept && !req_we && !misalign) ? load_data : '0;
            for (int i = 1; i < READ_LAT; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                m_pipe[i] <= m_pipe[i-1];
                d_pipe[i] <= d_pipe[i-1];
            end
        end
    end

    assign rsp_valid    = v_pipe[READ_LAT-1];
    assign rsp_misalign = m_pipe[READ_LAT-1];
    assign rsp_rdata    = d_pipe[READ_LAT-1];

`ifdef DMEM_STATS_EN
    // Saturating activity counters, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_faults <= '0;
        end else if (accept) begin
            if (!req_we && stat_loads != '1) begin
                stat_loads <= stat_loads + 1'b1;
            end
            if (req_we && stat_stores != '1) begin
                stat_stores <= stat_stores + 1'b1;
            end
            if (misalign && stat_faults != '1) begin
                stat_faults <= stat_faults + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl. Two instances share stimulus:
// one with READ_LAT=1 for functional checks and one with READ_LAT=3 for
// pipeline latency and in-flight reset checks. Both use a 256-byte array.
module tb_dmem_ctrl;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          clr_start;

    logic          req_ready,  req_ready3;
    logic          rsp_valid,  rsp_valid3;
    logic [DW-1:0] rsp_rdata,  rsp_rdata3;
    logic          rsp_misalign, rsp_misalign3;
    logic          clr_busy,   clr_busy3;
`ifdef DMEM_STATS_EN
    logic [31:0]   statLoads,  statStores,  statFaults;
    logic [31:0]   statLoads3, statStores3, statFaults3;
`endif

    int passCount  = 0;
    int failCount  = 0;
    int totalCount = 0;

    dmem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_misalign(rsp_misalign), .clr_start(clr_start), .clr_busy(clr_busy)
`ifdef DMEM_STATS_EN
        , .stat_loads(statLoads), .stat_stores(statStores), .stat_faults(statFaults)
`endif
    );

    dmem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready3), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3),
        .rsp_misalign(rsp_misalign3), .clr_start(clr_start), .clr_busy(clr_busy3)
`ifdef DMEM_STATS_EN
        , .stat_loads(statLoads3), .stat_stores(statStores3), .stat_faults(statFaults3)
`endif
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Watchdog so the run always ends even if the design stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkRsp(input string tag, input logic mis, input logic [31:0] data);
        checkOutput(tag, {6'b0, rsp_valid, rsp_misalign, rsp_rdata}, {6'b0, 1'b1, mis, data});
    endtask

    task automatic checkRsp3(input string tag, input logic mis, input logic [31:0] data);
        checkOutput(tag, {6'b0, rsp_valid3, rsp_misalign3, rsp_rdata3}, {6'b0, 1'b1, mis, data});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [7:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        tick();
        req_valid    = 1'b0;
        req_we       = 1'b0;
    endtask

    task automatic readWord(input logic [7:0] addr, output logic [31:0] data);
        applyStimulus(1'b0, 2'd2, 1'b0, addr, 32'h0);
        data = rsp_rdata;
    endtask

    // Directed sequence
    initial begin
        logic [31:0] rd;
        int          busyCycles;
        int          readyBad;
        int          badWords;
        logic        sawValid;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; clr_start = 1'b0;

        // Reset state
        tick();
        tick();
        checkOutput("rst_ready_low", {39'b0, req_ready}, 40'd0);
        checkOutput("rst_outputs", {5'b0, rsp_valid, rsp_misalign, clr_busy, rsp_rdata}, 40'd0);
        checkOutput("rst_outputs_lat3", {5'b0, rsp_valid3, rsp_misalign3, clr_busy3, rsp_rdata3}, 40'd0);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_rst", {39'b0, req_ready}, 40'd1);

        // Word store then load
        applyStimulus(1'b1, 2'd2, 1'b0, 8'h10, 32'h8899AABB);
        checkRsp("store_word_rsp", 1'b0, 32'h0);
        applyStimulus(1'b0, 2'd2, 1'b0, 8'h10, 32'h0);
        checkRsp("load_word", 1'b0, 32'h8899AABB);

        // Byte store only touches one byte, upper wdata bits ignored
        applyStimulus(1'b1, 2'd0, 1'b0, 8'h11, 32'hFFFFFF7F);
        checkRsp("store_byte_rsp", 1'b0, 32'h0);
        applyStimulus(1'b0, 2'd2, 1'b0, 8'h10, 32'h0);
        checkRsp("load_word_after_sb", 1'b0, 32'h88997FBB);
        applyStimulus(1'b0, 2'd0, 1'b0, 8'h13, 32'h0);
        checkRsp("lb_signed", 1'b0, 32'hFFFFFF88);
        applyStimulus(1'b0, 2'd1, 1'b1, 8'h12, 32'h0);
        checkRsp("lh_unsigned", 1'b0, 32'h00008899);
        applyStimulus(1'b0, 2'd1, 1'b0, 8'h12, 32'h0);
        checkRsp("lh_signed", 1'b0, 32'hFFFF8899);
        applyStimulus(1'b0, 2'd1, 1'b0, 8'h10, 32'h0);
        checkRsp("lh_signed_pos", 1'b0, 32'h00007FBB);
        applyStimulus(1'b0, 2'd0, 1'b1, 8'h10, 32'h0);
        checkRsp("lb_unsigned", 1'b0, 32'h000000BB);

        // Misaligned accesses
        applyStimulus(1'b1, 2'd1, 1'b0, 8'h13, 32'h00001234);
        checkRsp("sh_misalign", 1'b1, 32'h0);
`ifdef DMEM_STATS_EN
        checkOutput("stat_faults", {8'b0, statFaults}, 40'd1);
`endif
        applyStimulus(1'b0, 2'd2, 1'b0, 8'h10, 32'h0);
        checkRsp("word_after_bad_sh", 1'b0, 32'h88997FBB);
        applyStimulus(1'b0, 2'd2, 1'b0, 8'h12, 32'h0);
        checkRsp("lw_misalign", 1'b1, 32'h0);
        applyStimulus(1'b0, 2'd3, 1'b0, 8'h10, 32'h0);
        checkRsp("dword_on_32bit", 1'b1, 32'h0);

        // Back-to-back loads through both latencies
        applyStimulus(1'b1, 2'd2, 1'b0, 8'h00, 32'h11111111);
        applyStimulus(1'b1, 2'd2, 1'b0, 8'h04, 32'h22222222);
        applyStimulus(1'b1, 2'd2, 1'b0, 8'h08, 32'h33333333);
        tick();
        tick();
        tick();
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 8'h00;
        tick();
        checkOutput("lat3_e0_idle", {39'b0, rsp_valid3}, 40'd0);
        checkRsp("lat1_b2b_0", 1'b0, 32'h11111111);
        req_addr = 8'h04;
        tick();
        checkOutput("lat3_e1_idle", {39'b0, rsp_valid3}, 40'd0);
        checkRsp("lat1_b2b_1", 1'b0, 32'h22222222);
        req_addr = 8'h08;
        tick();
        req_valid = 1'b0;
        checkRsp3("lat3_rsp_0", 1'b0, 32'h11111111);
        checkRsp("lat1_b2b_2", 1'b0, 32'h33333333);
        tick();
        checkRsp3("lat3_rsp_1", 1'b0, 32'h22222222);
        tick();
        checkRsp3("lat3_rsp_2", 1'b0, 32'h33333333);
        tick();
        checkOutput("lat3_drained", {39'b0, rsp_valid3}, 40'd0);

        // Fill the array, then clear with a colliding request
        for (int w = 0; w < 64; w++) begin
            applyStimulus(1'b1, 2'd2, 1'b0, 8'(w * 4), 32'hA5000000 | 32'(w));
        end
        tick();
        tick();
        tick();
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 8'h80;
        req_wdata = 32'hDEADBEEF; clr_start = 1'b1;
        #1;
        checkOutput("clr_collide_ready", {39'b0, req_ready}, 40'd0);
        tick();
        req_valid = 1'b0; req_we = 1'b0; clr_start = 1'b0;
        checkOutput("clr_collide_no_rsp", {39'b0, rsp_valid}, 40'd0);
        busyCycles = 0;
        readyBad   = 0;
        for (int c = 0; c < 200 && clr_busy; c++) begin
            busyCycles++;
            if (req_ready) readyBad++;
            if (c == 10) clr_start = 1'b1;
            tick();
            clr_start = 1'b0;
        end
        checkOutput("clr_busy_cycles", 40'(busyCycles), 40'd64);
        checkOutput("clr_ready_low", 40'(readyBad), 40'd0);
        checkOutput("clr_done_ready", {39'b0, req_ready}, 40'd1);
        badWords = 0;
        for (int w = 0; w < 64; w++) begin
            readWord(8'(w * 4), rd);
            if (rd !== 32'h0) badWords++;
        end
        checkOutput("clr_all_zero", 40'(badWords), 40'd0);

        // Reset in the middle of a clear
        for (int w = 0; w < 64; w++) begin
            applyStimulus(1'b1, 2'd2, 1'b0, 8'(w * 4), 32'hC3000000 | 32'(w));
        end
        tick();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (20) tick();
        checkOutput("mid_busy", {39'b0, clr_busy}, 40'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_abort_busy", {39'b0, clr_busy}, 40'd0);
        #1;
        checkOutput("mid_abort_ready", {39'b0, req_ready}, 40'd1);
        badWords = 0;
        for (int w = 0; w < 20; w++) begin
            readWord(8'(w * 4), rd);
            if (rd !== 32'h0) badWords++;
        end
        checkOutput("mid_low_zero", 40'(badWords), 40'd0);
        readWord(8'd84, rd);
        checkOutput("mid_word21_kept", {8'b0, rd}, {8'b0, 32'hC3000015});
        readWord(8'd160, rd);
        checkOutput("mid_word40_kept", {8'b0, rd}, {8'b0, 32'hC3000028});
        readWord(8'd252, rd);
        checkOutput("mid_word63_kept", {8'b0, rd}, {8'b0, 32'hC300003F});

        // Reset drops an in-flight response
        tick();
        tick();
        tick();
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 8'd160;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        sawValid = 1'b0;
        repeat (2) begin
            tick();
            sawValid = sawValid | rsp_valid3;
        end
        rst = 1'b0;
        repeat (3) begin
            tick();
            sawValid = sawValid | rsp_valid3;
        end
        checkOutput("inflight_dropped", {39'b0, sawValid}, 40'd0);
        req_valid = 1'b1; req_addr = 8'd160;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checkRsp3("lat3_after_rst", 1'b0, 32'hC3000028);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised byte-addressed data memory for the MEM stage of the 5-stage pipeline; successor to the fixed 64 KiB word SRAM.
- Little-endian byte array with byte, half and word access and sign/zero-extended loads.
- Aligned-access enforcement with a misalignment flag, and a configurable in-order read pipeline.
- Hardware bulk-clear state machine.

Parameters:
- ADDR_W, 16, byte-address width; array holds 2**ADDR_W bytes.
- DATA_W, 32, data path width; must be 32 or 64; DATA_W/8 byte lanes.
- READ_LAT, 1, response latency in cycles after accept; legal range 1..4.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword (dword only when DATA_W=64; otherwise treated as misaligned).
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified (low bytes used).
- rsp_valid  out  1  response valid, one cycle per accepted request.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and faults.
- rsp_misalign  out  1  accepted request was misaligned; no write performed.
- clr_start  in  1  pulse: begin zeroing entire array.
- clr_busy  out  1  clear in progress.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_misalign=0, clr_busy=0, FSM=IDLE, latency pipeline emptied. req_ready=0 while rst=1. Memory contents are NOT reset.
- FSM states:
  - IDLE: req_ready = !clr_start.
  - CLEAR: req_ready=0, clr_busy=1.
- Transitions:
  - IDLE -> CLEAR when clr_start=1. clr_start takes priority over a same-cycle req_valid; that request is not accepted.
  - CLEAR writes DATA_W/8 zero bytes per cycle at word index 0,1,... upward. CLEAR -> IDLE on the edge writing the last word; clr_busy drops the next cycle.
  - Clear takes exactly 2**ADDR_W/(DATA_W/8) cycles.
  - clr_start is ignored while in CLEAR.
- Alignment: access is aligned when req_addr mod size-bytes == 0. Misaligned store: array unchanged. Misaligned load: rdata=0. Both respond with rsp_misalign=1.
- Store: at the accept edge, bytes addr..addr+n-1 take req_wdata[8n-1:0]; all other bytes unchanged. Stores produce a response with rdata=0 and misalign as computed.
- Load: array read at the accept edge, seeing all stores accepted on earlier edges. Extension is from bit 8n-1 to DATA_W.
- Latency: response appears exactly READ_LAT cycles after the accept edge.
  - READ_LAT=1: rsp_valid high in the cycle after accept.
  - Full throughput of one request per cycle, strictly in order. No response backpressure.
- In-flight responses drain normally during CLEAR; load data captured before clear is unaffected.
- Reset mid-clear: clear aborted, array partially zeroed, FSM returns to IDLE. Reset with responses in flight: those responses are dropped.
- Address wrap: aligned accesses cannot wrap; no wrap logic is required.

Optional Feature:
- Macro: DMEM_STATS_EN.
- When defined, add three outputs, each 32 bits, saturating at 0xFFFFFFFF, cleared by rst (not by clear):
  - stat_loads: counts accepted loads.
  - stat_stores: counts accepted stores.
  - stat_faults: counts misaligned requests.
- When undefined, these ports and counters are absent; the module interface is the base list only.

Test Plan:
- ADDR_W=8, DATA_W=32, READ_LAT=1: store word 0x8899AABB @0x10, next cycle load word @0x10 -> rsp_valid one cycle later, rdata=0x8899AABB, misalign=0.
- Store byte 0x7F @0x11 over previous word -> load word @0x10 returns 0x88997FBB. Load byte signed @0x13 -> 0xFFFFFF88. Load half unsigned @0x12 -> 0x00008899.
- Store half @0x13 -> rsp_misalign=1, rdata=0; subsequent load word @0x10 still 0x88997FBB. With DMEM_STATS_EN, stat_faults=1.
- READ_LAT=3: back-to-back loads @0x0,0x4,0x8 on consecutive cycles -> three consecutive rsp_valid cycles starting 3 cycles after the first accept, data in order.
- Fill array, pulse clr_start with req_valid=1 same cycle -> request not accepted, clr_busy high for exactly 64 cycles, req_ready low throughout; afterwards every word reads 0.
- Assert rst at clear cycle 20 -> clr_busy=0 next cycle; word 0..19 read 0, word 40 retains prior data; in-flight response suppressed.
